// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
package mux4_arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    localparam int N_REQ = 4;

    typedef logic [1:0] req_idx_t;

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod 4.
module rr_pick_4
    import mux4_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  req_idx_t         ptr,
    output logic             any,
    output req_idx_t         idx
);

    req_idx_t         pos [N_REQ];
    logic [N_REQ-1:0] rot;

    // rot[k] is the request k places after ptr; 2-bit addition gives the wrap.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign pos[gi] = ptr + req_idx_t'(gi);
            assign rot[gi] = req[pos[gi]];
        end
    endgenerate

    always_comb begin
        any = |req;
        idx = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = pos[k];
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Four requesters share one W-bit 4:1 mux; round-robin grants with bursts of up to
// MAX_BURST beats feeding a single registered output stage with valid/ready.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int W         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     d0,
    input  logic [W-1:0]     d1,
    input  logic [W-1:0]     d2,
    input  logic [W-1:0]     d3,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] req_ready,
    output logic [N_REQ-1:0] grant,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [1:0]       out_src,
    input  logic             out_ready
);

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    arb_state_t   state_reg, state_next;
    req_idx_t     ptr_reg;
    req_idx_t     owner_reg;
    logic [7:0]   beat_cnt_reg;
    logic         out_valid_reg;
    logic [W-1:0] out_data_reg;
    req_idx_t     out_src_reg;

    logic         pick_any;
    req_idx_t     pick_idx;
    logic         can_load;
    logic         xfer;
    logic         release_burst;
    logic [W-1:0] d_arr [N_REQ];
    logic [W-1:0] mux_data;

    rr_pick_4 u_pick (
        .req (req_valid),
        .ptr (ptr_reg),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign d_arr[0] = d0;
    assign d_arr[1] = d1;
    assign d_arr[2] = d2;
    assign d_arr[3] = d3;
    assign mux_data = d_arr[owner_reg];

    assign can_load = !out_valid_reg || out_ready;

    always_comb begin
        state_next    = state_reg;
        grant         = '0;
        req_ready     = '0;
        xfer          = 1'b0;
        release_burst = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                grant[owner_reg]     = 1'b1;
                req_ready[owner_reg] = can_load;
                xfer                 = req_valid[owner_reg] && can_load;
                // A withdrawn owner releases immediately; a stalled owner keeps its count.
                if (!req_valid[owner_reg] || (xfer && beat_cnt_reg == LAST_BEAT)) begin
                    release_burst = 1'b1;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            owner_reg    <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && pick_any) begin
                owner_reg    <= pick_idx;
                beat_cnt_reg <= '0;
            end else if (xfer) begin
                beat_cnt_reg <= beat_cnt_reg + 8'd1;
            end
            if (release_burst) begin
                ptr_reg <= owner_reg + req_idx_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_src_reg   <= '0;
        end else if (xfer) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= mux_data;
            out_src_reg   <= owner_reg;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: MAX_BURST=4 and MAX_BURST=1 instances share stimulus,
// a per-instance behavioural model is compared every cycle, plus directed literal checks.
module tb_mux4_rr_arbiter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic [3:0]   req_valid = '0;
    logic         out_ready = 1'b1;

    logic [3:0]   rr [2];
    logic [3:0]   gnt [2];
    logic         ov [2];
    logic [W-1:0] od [2];
    logic [1:0]   os [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mux4_rr_arbiter #(.W(W), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .req_valid(req_valid), .req_ready(rr[0]), .grant(gnt[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_src(os[0]), .out_ready(out_ready)
    );

    mux4_rr_arbiter #(.W(W), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .req_valid(req_valid), .req_ready(rr[1]), .grant(gnt[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_src(os[1]), .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int burst [2] = '{4, 1};
    bit m_busy [2];
    int m_owner [2];
    int m_ptr [2];
    int m_beats [2];
    bit m_ov [2];
    int m_od [2];
    int m_os [2];

    function automatic int dsel(input int i);
        case (i)
            0: return int'(d0);
            1: return int'(d1);
            2: return int'(d2);
            default: return int'(d3);
        endcase
    endfunction

    task automatic model_step(input int k);
        bit can;
        bit found;
        if (!rst_n) begin
            m_busy[k] = 0; m_owner[k] = 0; m_ptr[k] = 0; m_beats[k] = 0;
            m_ov[k] = 0; m_od[k] = 0; m_os[k] = 0;
        end else begin
            can = !m_ov[k] || out_ready;
            if (!m_busy[k]) begin
                if (out_ready) m_ov[k] = 0;
                if (req_valid != 4'b0000) begin
                    found = 0;
                    for (int j = 0; j < 4; j++) begin
                        if (!found && req_valid[(m_ptr[k] + j) % 4]) begin
                            m_owner[k] = (m_ptr[k] + j) % 4;
                            found = 1;
                        end
                    end
                    m_busy[k] = 1;
                    m_beats[k] = 0;
                end
            end else if (!req_valid[m_owner[k]]) begin
                if (out_ready) m_ov[k] = 0;
                m_busy[k] = 0;
                m_ptr[k] = (m_owner[k] + 1) % 4;
            end else if (can) begin
                m_ov[k] = 1;
                m_od[k] = dsel(m_owner[k]);
                m_os[k] = m_owner[k];
                m_beats[k]++;
                if (m_beats[k] == burst[k]) begin
                    m_busy[k] = 0;
                    m_ptr[k] = (m_owner[k] + 1) % 4;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    initial begin
        int eg, er;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                eg = m_busy[k] ? (1 << m_owner[k]) : 0;
                er = (m_busy[k] && (!m_ov[k] || out_ready)) ? (1 << m_owner[k]) : 0;
                chk($sformatf("model_grant[%0d]", k), 32'(gnt[k]), 32'(eg));
                chk($sformatf("model_req_ready[%0d]", k), 32'(rr[k]), 32'(er));
                chk($sformatf("model_out_valid[%0d]", k), 32'(ov[k]), 32'(m_ov[k]));
                chk($sformatf("model_out_data[%0d]", k), 32'(od[k]), 32'(m_od[k]));
                chk($sformatf("model_out_src[%0d]", k), 32'(os[k]), 32'(m_os[k]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int acc;
        int s;

        // 1: single requester 2
        do_reset();
        chk("t1_reset_out_valid", 32'(ov[0]), 0);
        chk("t1_reset_grant", 32'(gnt[0]), 0);
        for (int c = 0; c < 10; c++) begin
            cyc();
            req_valid = (c < 5) ? 4'b0100 : 4'b0000;
            d2 = 4'hC;
            #1;
            if (c == 0) chk("t1_grant_c0", 32'(gnt[0]), 0);
            if (c == 1) begin
                chk("t1_grant_c1", 32'(gnt[0]), 4'b0100);
                chk("t1_ready_c1", 32'(rr[0]), 4'b0100);
            end
            if (c == 2) begin
                chk("t1_out_valid_c2", 32'(ov[0]), 1);
                chk("t1_out_data_c2", 32'(od[0]), 4'hC);
                chk("t1_out_src_c2", 32'(os[0]), 2);
                chk("t1_grant_held_c2", 32'(gnt[0]), 4'b0100);
            end
        end

        // 2: all four requesting, bursts of 4 rotating 0,1,2,3,0
        do_reset();
        d0 = 4'hA; d1 = 4'hB; d2 = 4'hC; d3 = 4'hD;
        for (int c = 0; c < 27; c++) begin
            cyc();
            req_valid = 4'b1111;
            #1;
            if (c >= 2) begin
                s = ((c - 2) / 5) % 4;
                chk("t2_out_valid", 32'(ov[0]), ((c - 2) % 5 != 4) ? 1 : 0);
                if ((c - 2) % 5 != 4) begin
                    chk("t2_out_src", 32'(os[0]), 32'(s));
                    chk("t2_out_data", 32'(od[0]), 32'(10 + s));
                end
            end
        end

        // 3: back-pressure on owner 1 mid-burst
        do_reset();
        acc = 0;
        for (int c = 0; c < 9; c++) begin
            cyc();
            req_valid = 4'b0010;
            d1 = 4'(5 + acc);
            out_ready = !(c >= 3 && c <= 5);
            #1;
            if (rr[0][1] && req_valid[1]) acc++;
            if (c >= 3 && c <= 5) begin
                chk("t3_stall_ready", 32'(rr[0]), 0);
                chk("t3_stall_valid", 32'(ov[0]), 1);
                chk("t3_stall_data", 32'(od[0]), 6);
                chk("t3_stall_grant", 32'(gnt[0]), 4'b0010);
            end
            if (c == 8) begin
                chk("t3_beats", 32'(acc), 4);
                chk("t3_idle_grant", 32'(gnt[0]), 0);
            end
        end
        out_ready = 1'b1;

        // 4: owner 0 withdraws after 2 beats, requester 3 waiting
        do_reset();
        d0 = 4'h1; d3 = 4'h3;
        for (int c = 0; c < 7; c++) begin
            cyc();
            req_valid = (c < 3) ? 4'b1001 : 4'b1000;
            #1;
            if (c == 1) chk("t4_grant_c1", 32'(gnt[0]), 4'b0001);
            if (c == 3) chk("t4_grant_c3", 32'(gnt[0]), 4'b0001);
            if (c == 4) begin
                chk("t4_grant_idle", 32'(gnt[0]), 0);
                chk("t4_ready_idle", 32'(rr[0]), 0);
            end
            if (c == 5) chk("t4_grant_c5", 32'(gnt[0]), 4'b1000);
        end

        // 5: MAX_BURST=1 instance alternates 0,1 every other cycle
        do_reset();
        d0 = 4'h6; d1 = 4'h7;
        for (int c = 0; c < 10; c++) begin
            cyc();
            req_valid = 4'b0011;
            #1;
            if (c == 1) chk("t5_grant_c1", 32'(gnt[1]), 4'b0001);
            if (c == 3) chk("t5_grant_c3", 32'(gnt[1]), 4'b0010);
            if (c >= 2) begin
                chk("t5_out_valid", 32'(ov[1]), (c % 2 == 0) ? 1 : 0);
                if (c % 2 == 0) begin
                    chk("t5_out_src", 32'(os[1]), 32'(((c - 2) / 2) % 2));
                    chk("t5_out_data", 32'(od[1]), 32'(6 + ((c - 2) / 2) % 2));
                end
            end
        end

        // 6: reset mid-burst
        do_reset();
        d0 = 4'h9;
        for (int c = 0; c < 4; c++) begin
            cyc();
            req_valid = 4'b0001;
            #1;
        end
        chk("t6_pre_valid", 32'(ov[0]), 1);
        chk("t6_pre_grant", 32'(gnt[0]), 4'b0001);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(ov[0]), 0);
        chk("t6_rst_grant", 32'(gnt[0]), 0);
        chk("t6_rst_ready", 32'(rr[0]), 0);
        chk("t6_rst_data", 32'(od[0]), 0);
        @(posedge clk);
        #2;
        req_valid = 4'b1011;
        rst_n = 1'b1;
        cyc();
        #1;
        chk("t6_first_grant", 32'(gnt[0]), 4'b0001);
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Shares one W-bit 4:1 mux datapath between four requesters using valid/ready handshakes.
- Grants are round-robin; the owner keeps the grant for a burst of up to MAX_BURST beats.
- The selected beat lands in a single output register with its own valid/ready handshake.
- Sits between independent producers and one downstream consumer; owns the mux select.

Parameters:
W, 4, data width of each requester and of the output.
MAX_BURST, 4, maximum accepted beats per grant (legal range 1..255).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous reset, active low.
d0  input  W  requester 0 data.
d1  input  W  requester 1 data.
d2  input  W  requester 2 data.
d3  input  W  requester 3 data.
req_valid  input  4  bit i = requester i has a beat.
req_ready  output  4  bit i = beat from requester i accepted this cycle.
grant  output  4  one-hot current owner; all zero when idle.
out_valid  output  1  output register holds a beat.
out_data  output  W  registered selected data.
out_src  output  2  index of the requester that produced out_data.
out_ready  input  1  downstream accepts out_data.

Behaviour:
- Reset values (async, rst_n=0):
  - state=IDLE, ptr=0, owner=0, beat_cnt=0.
  - out_valid=0, out_data=0, out_src=0.
  - grant=0, req_ready=0.
- can_load = !out_valid || out_ready.
- IDLE state:
  - req_ready=0 and grant=0.
  - If any req_valid bit is set, the winner is the first set index scanning ptr, ptr+1, ... mod 4.
  - Next state BUSY; owner<=winner; beat_cnt<=0.
  - No transfer occurs in the arbitration cycle.
- BUSY state:
  - grant=onehot(owner).
  - req_ready[owner]=can_load; all other req_ready bits are 0.
  - Mux select = owner.
- Transfer (req_valid[owner] && req_ready[owner]):
  - out_data<=d[owner], out_src<=owner, out_valid<=1.
  - beat_cnt<=beat_cnt+1.
- Release from BUSY to IDLE, with ptr<=(owner+1) mod 4 (2-bit wrap, 3->0), when either:
  - a transfer happens with beat_cnt==MAX_BURST-1 (the burst-final beat is still transferred), or
  - req_valid[owner]==0 in BUSY (owner withdrew); no transfer that cycle.
- Back-pressure:
  - With out_ready=0 and out_valid=1, req_ready stays 0.
  - Grant is held and beat_cnt is frozen; the stall does not count against the burst.
- Output register:
  - Cleared (out_valid<=0) when out_ready=1 and no transfer occurs.
  - Loaded and drained in the same cycle when both happen: full throughput, 1 beat/cycle.
- Latency: req_valid rises in cycle 0 (IDLE) -> grant and req_ready in cycle 1 -> out_valid in cycle 2.
- Re-arbitration always costs exactly one IDLE cycle between grants.
- MAX_BURST=1 gives per-beat rotation, one beat every 2 cycles.
- Inputs of non-owners are ignored; they need not hold stable until granted, but must obey valid/ready (no data change while valid && !ready).
- Reset mid-burst: every output drops immediately; the in-flight beat in the output register is lost.
- Never: two grant bits set; req_ready asserted for a non-owner; req_ready asserted in IDLE.

Decomposition:
- Package mux4_arb_pkg holds:
  - typedef enum logic {IDLE, BUSY} arb_state_t;
  - localparam N_REQ=4;
  - typedef logic [1:0] req_idx_t.
- Sub-module rr_pick_4: combinational. Inputs req[3:0] and ptr[1:0]; outputs any and idx[1:0] (first set bit at or after ptr).
- The data mux is a W-bit 4:1 select on owner inside the top level.

Test Plan:
1. Reset then single requester: req_valid=0100, d2=0xC, out_ready=1 -> grant=0100 at cycle 1; out_valid=1, out_data=0xC, out_src=2 at cycle 2; grant held while valid.
2. All four requesting continuously, data 0xA,0xB,0xC,0xD, MAX_BURST=4, out_ready=1:
   - Bursts of 4 beats in order src 0,1,2,3,0 (ptr wraps 3->0).
   - One idle cycle between bursts.
3. Back-pressure: owner 1 mid-burst, out_ready=0 for 3 cycles:
   - req_ready=0 and out_data stays the same.
   - beat_cnt is unchanged; burst still delivers exactly 4 beats after release.
4. Owner withdraws: requester 0 drops valid after 2 beats while requester 3 waits -> IDLE one cycle, then grant=1000 (ptr=1 scans 1,2,3).
5. MAX_BURST=1, requesters 0 and 1 both valid -> out_src alternates 0,1,0,1 with out_valid pulsing every other cycle.
6. Assert rst_n=0 mid-burst with out_valid=1 -> out_valid, grant, req_ready go 0 immediately; after release the first grant goes to requester 0 (ptr=0).
